// File: rtl/key_expansion_seq_pkg.sv
// Shared definitions for the iterative AES key schedule: FSM encoding,
// the AES S-box, the GF(2^8) doubling helper and the schedule-size helper.
package key_expansion_seq_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Forward S-box, entry 0x00 in the top byte (same table as SubBytes).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8); 8'h80 wraps to 8'h1b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Total schedule words for a given round count.
  function automatic int num_words(input int nr);
    return 4 * (nr + 1);
  endfunction

endpackage

// File: rtl/key_expansion_seq_sub_word.sv
// Combinational SubWord: four independent S-box lookups on a 32-bit word.
module key_expansion_seq_sub_word
  import key_expansion_seq_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign o_word[8*gi +: 8] = sbox(i_word[8*gi +: 8]);
  end

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule: one 32-bit word per clock into a flat
// round-key bus, with a single shared SubWord datapath.
module key_expansion_seq
  import key_expansion_seq_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [Nk*32-1:0]        key,
  output logic [(Nr+1)*128-1:0]   allKeys,
  output logic                    busy,
  output logic                    done,
  output logic                    keysValid
);

  localparam int NW = num_words(Nr);
  localparam int IW = $clog2(NW + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [IW-1:0]       r_i;
  logic [3:0]          r_mod;      // i mod Nk, kept as a wrapping counter
  logic [7:0]          r_rcon;
  logic                r_done;
  logic                r_valid;

  logic [NW-1:0][31:0] w_words;
  logic [31:0]         w_prev;
  logic [31:0]         w_back;
  logic [31:0]         w_sub_in;
  logic [31:0]         w_sub_out;
  logic [31:0]         w_temp;
  logic [31:0]         w_new;
  logic                w_is_rot;
  logic                w_is_sub4;
  logic                w_last;
  logic                w_accept;
  logic                w_expanding;

  assign w_expanding = (r_state == ST_EXPAND);
  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_last      = (r_i == IW'(NW - 1));
  assign w_is_rot    = (r_mod == 4'd0);
  assign w_is_sub4   = (Nk > 6) && (r_mod == 4'd4);

  // Operands w[i-1] and w[i-Nk]; only meaningful while expanding.
  assign w_prev = w_words[r_i - IW'(1)];
  assign w_back = w_words[r_i - IW'(Nk)];

  // Single SubWord shared by the RotWord path and the 256-bit mid-key path.
  assign w_sub_in = w_is_rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  key_expansion_seq_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // Select the transformed temp word and form the new schedule word.
  always_comb begin
    w_temp = w_prev;
    if (w_is_rot) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h000000};
    end else if (w_is_sub4) begin
      w_temp = w_sub_out;
    end
    w_new = w_back ^ w_temp;
  end

  // Word storage: key words load on start, schedule words fill in order.
  for (genvar gi = 0; gi < NW; gi++) begin : g_word
    logic [31:0] r_word;

    if (gi < Nk) begin : g_key
      // Key word: captured only when a start is accepted.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_word <= '0;
        end else if (w_accept) begin
          r_word <= key[Nk*32-32*gi-1 -: 32];
        end
      end
    end else begin : g_sched
      // Derived word: cleared on start, written once when i reaches it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_word <= '0;
        end else if (w_accept) begin
          r_word <= '0;
        end else if (w_expanding && (r_i == IW'(gi))) begin
          r_word <= w_new;
        end
      end
    end

    assign w_words[gi] = r_word;
    assign allKeys[(Nr+1)*128-32*gi-1 -: 32] = r_word;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: start only matters in IDLE; leave after the last word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start)  w_state_next = ST_EXPAND;
      ST_EXPAND: if (w_last) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Word index, modulo counter, rcon and completion flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i     <= '0;
      r_mod   <= '0;
      r_rcon  <= 8'h01;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_i     <= IW'(Nk);
        r_mod   <= '0;
        r_rcon  <= 8'h01;
        r_valid <= 1'b0;
      end else if (w_expanding) begin
        r_i   <= r_i + IW'(1);
        r_mod <= (r_mod == 4'(Nk - 1)) ? 4'd0 : r_mod + 4'd1;
        if (w_is_rot) begin
          r_rcon <= xtime(r_rcon);
        end
        if (w_last) begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
        end
      end
    end
  end

  // FSM outputs.
  always_comb begin
    busy      = w_expanding;
    done      = r_done;
    keysValid = r_valid;
  end

endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
Iterative AES key schedule that fills the flat round-key bus consumed by the round-iterative encrypt core. It produces one 32-bit schedule word per clock, so only one SubWord datapath is needed instead of a fully combinational expansion. It supports AES-128/192/256 through Nk/Nr and signals completion with a done pulse and a level keysValid.

Parameters:
Nk, 4, key length in 32-bit words (4, 6 or 8)
Nr, 10, number of rounds (10, 12 or 14); total schedule words NW = 4*(Nr+1)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request expansion of key; sampled only in IDLE
key  input  Nk*32  cipher key; w[0] is the MSB word
allKeys  output  (Nr+1)*128  round keys; round 0 in the top 128 bits; word w[i] at allKeys[(Nr+1)*128-32*i-1 -: 32]
busy  output  1  high while expanding
done  output  1  one-cycle pulse when the last word has been written
keysValid  output  1  high from done until the next accepted start or reset

Behaviour:
- Reset (async, any state): state=IDLE, allKeys=0, busy=0, done=0, keysValid=0, word index i=0, rcon=8'h01.
- FSM states: IDLE, EXPAND.
- IDLE with start=1:
  - Latch key into w[0..Nk-1] in allKeys; clear all other words to 0.
  - Set i=Nk, rcon=8'h01, busy=1, keysValid=0; go to EXPAND.
  - key is not sampled again, so later changes are ignored.
- IDLE with start=0: hold all outputs; done=0.
- EXPAND, once per cycle:
  - Compute temp=w[i-1].
  - If i mod Nk==0: temp=SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon=xtime(rcon), where 8'h80 maps to 8'h1B.
  - Else if Nk>6 and i mod Nk==4: temp=SubWord(temp).
  - Write w[i]=w[i-Nk]^temp; then i=i+1.
  - Use a modulo-Nk counter rather than a divider.
- Terminal word (i==NW-1): write it, then in the same edge set done=1 (one cycle), keysValid=1, busy=0 and return to IDLE.
- Latency: the start edge loads the key; the next NW-Nk edges write one word each; done is high after edge NW-Nk.
  - AES-128: 40 cycles; AES-192: 46; AES-256: 52.
- start while busy: ignored, with no effect on i, rcon or outputs.
- start in the cycle done is high: the FSM is already IDLE, so it is accepted; keysValid drops on the next edge.
- Partial results: during EXPAND, words below i are final and words at i and above read 0. Consumers must wait for keysValid.
- Reset mid-expansion: returns immediately to the reset values; no done pulse.
- Index widths: i needs ceil(log2(NW+1)) bits (6 bits covers NW=60). rcon is 8 bits.

Decomposition:
- Shared include holds:
  - the 256-entry S-box table (the same one used by SubBytes);
  - the xtime function;
  - the localparam NW=4*(Nr+1);
  - the FSM state encodings.
- One sub-module, sub_word: a 32-bit combinational SubWord built from four S-box lookups, instantiated once and shared by the RotWord and Nk>6 paths through an input mux.

Test Plan:
- Nk=4/Nr=10, key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> done after 40 cycles; w[4..7]=a0fafe17 88542cb1 23a33939 2a6c7605; round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6; keysValid=1.
- Nk=4, key 000102030405060708090a0b0c0d0e0f -> round-1 key d6aa74fdd2af72fadaa678f1d6ab76fe; round-10 key 13111d7fe3944a17f307a78b4d2b30c5; result drives the encrypt core to ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Nk=6/Nr=12, key 000102…1617 -> done after 46 cycles; round-12 key a4970a331a78dc09c418c271e3a41d5d.
- Nk=8/Nr=14, key 000102…1e1f -> done after 52 cycles; round-14 key 24fc79ccbf0979e9371ac23c6d68de36 (checks the i mod 8==4 SubWord path).
- Protocol checks (Nk=4):
  - start re-pulsed at cycle 10 -> ignored, done still at cycle 40;
  - reset at cycle 20 -> allKeys=0, busy=0, no done;
  - a fresh start then completes normally;
  - start on the done cycle with a new key -> accepted, keysValid drops next edge, second result correct.
